// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and latency for the multiply/divide unit
package muldiv_pkg;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam int MD_LATENCY = 33;
  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_e;
  function automatic logic md_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement of two halves, independently or as one double-width value
module muldiv_signfix #(
  parameter int H = 33
) (
  input  logic         joint,
  input  logic         neg_hi,
  input  logic         neg_lo,
  input  logic [H-1:0] x_hi,
  input  logic [H-1:0] x_lo,
  output logic [H-1:0] y_hi,
  output logic [H-1:0] y_lo
);
  logic [2*H-1:0] cat_n;
  assign cat_n = -{x_hi, x_lo};
  assign y_hi = !neg_hi ? x_hi : joint ? cat_n[2*H-1:H] : -x_hi;
  assign y_lo = joint ? (neg_hi ? cat_n[H-1:0] : x_lo) : (neg_lo ? -x_lo : x_lo);
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH:0] m_q, m_d;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic sres_q, sres_d, srem_q, srem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic done_q, done_d, div0_q, div0_d;
  logic sgn, rs_neg, rt_neg, is_div0;
  logic [WIDTH:0] rs_mag, rt_mag, m_sum, d_shift, d_rem;
  logic [WIDTH+1:0] d_diff;
  logic [2*WIDTH:0] step;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign sgn = md_is_signed(op);
  assign rs_neg = sgn & rs_val[WIDTH-1];
  assign rt_neg = sgn & rt_val[WIDTH-1];
  // Operand magnitudes: the extra top bit lets |-2^(WIDTH-1)| be represented exactly
  muldiv_signfix #(.H(WIDTH+1)) u_entry (
    .joint(1'b0), .neg_hi(rs_neg), .neg_lo(rt_neg),
    .x_hi({rs_neg, rs_val}), .x_lo({rt_neg, rt_val}),
    .y_hi(rs_mag), .y_lo(rt_mag)
  );
  // Result sign correction: the product is negated as one double-width value, quotient/remainder separately
  muldiv_signfix #(.H(WIDTH)) u_exit (
    .joint(!op_q[1]), .neg_hi(op_q[1] ? srem_q : sres_q), .neg_lo(sres_q),
    .x_hi(acc_q[2*WIDTH-1:WIDTH]), .x_lo(acc_q[WIDTH-1:0]),
    .y_hi(res_hi), .y_lo(res_lo)
  );
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign m_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? m_q : '0);
  assign d_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign d_diff = {1'b0, d_shift} - {1'b0, m_q};
  assign d_rem = d_diff[WIDTH+1] ? d_shift : d_diff[WIDTH:0];
  assign step = op_q[1] ? {d_rem, acc_q[WIDTH-2:0], !d_diff[WIDTH+1]} : {1'b0, m_sum, acc_q[WIDTH-1:1]};
  assign is_div0 = op_q[1] && (m_q == '0);
  // Next-state: launch from IDLE, iterate in CALC, commit the corrected result in FIX
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    m_d = m_q;
    acc_d = acc_q;
    sres_d = sres_q;
    srem_d = srem_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    div0_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        hi_d = wr_hi ? wdata : hi_q;
        lo_d = wr_lo ? wdata : lo_q;
        if (start && !abort) begin
          state_d = CALC;
          cnt_d = '0;
          op_d = op;
          m_d = op[1] ? rt_mag : rs_mag;
          acc_d = {{(WIDTH+1){1'b0}}, op[1] ? rs_mag[WIDTH-1:0] : rt_mag[WIDTH-1:0]};
          sres_d = rs_neg ^ rt_neg;
          srem_d = rs_neg;
        end
      end
      CALC: begin
        state_d = abort ? IDLE : (cnt_q == CNT_W'(WIDTH-1)) ? FIX : CALC;
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          div0_d = is_div0;
          hi_d = res_hi;
          lo_d = is_div0 ? '1 : res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      sres_q <= 1'b0;
      srem_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      m_q <= m_d;
      acc_q <= acc_d;
      sres_q <= sres_d;
      srem_q <= srem_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst, start, abort, wr_hi, wr_lo, busy, done, div0;
  logic [1:0] op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo;
  int n_cmp, n_bad;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div0, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (o)
      MD_MULT: p = sa * sb;
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: begin
        q = {32'b0, a} / {32'b0, b};
        r = {32'b0, a} % {32'b0, b};
        p = {r[31:0], q[31:0]};
      end
    endcase
    return {1'b0, p};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // One full operation; k>=0 injects a start and HI/LO writes k edges into the operation
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int k);
    logic [64:0] e;
    logic [31:0] h0, l0;
    int n;
    e = model(o, a, b);
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    check("busy_on", 64'(busy), 64'(1));
    while (busy && n < 100) begin
      if (n == k) begin
        op = ~o; rs_val = ~a; rt_val = b + 32'd3; start = 1'b1;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      if (n == k + 1) begin
        check("hold_hi", 64'(hi), 64'(h0));
        check("hold_lo", 64'(lo), 64'(l0));
      end
    end
    check("latency", 64'(n), 64'(MD_LATENCY));
    check("done", 64'(done), 64'(1));
    check("div0", 64'(div0), 64'(e[64]));
    check("hi", 64'(hi), 64'(e[63:32]));
    check("lo", 64'(lo), 64'(e[31:0]));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    logic [31:0] h0, l0;
    int n, dn;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0; wdata = '0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_div0", 64'(div0), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk) rst = 1'b0;

    @(negedge clk); wr_hi = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1 wr_hi = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    @(negedge clk); wr_lo = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1 wr_lo = 1'b0;
    check("mtlo", 64'(lo), 64'h5678);

    run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);
    run(MD_MULT, -32'd7, 32'd3, -1);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    run(MD_DIV, -32'd7, 32'd2, -1);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run(MD_DIVU, 32'd100, 32'd0, -1);
    run(MD_DIV, 32'h8000_0000, 32'd0, -1);
    run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    run(MD_MULT, 32'h8000_0000, 32'h8000_0000, -1);
    run(MD_DIVU, 32'd1000, 32'd7, 4);

    h0 = hi; l0 = lo;
    @(negedge clk); op = MD_DIVU; rs_val = 32'd12345; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(h0));
    check("abort_lo", 64'(lo), 64'(l0));
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1 dn += int'(done);
    end
    check("abort_no_done", 64'(dn), 64'(0));

    @(negedge clk); op = MD_MULTU; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("abort_start_idle", 64'(busy), 64'(0));

    @(negedge clk); op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1; wr_hi = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1 start = 1'b0; wr_hi = 1'b0;
    check("wr_start_hi", 64'(hi), 64'hABCD);
    check("wr_start_busy", 64'(busy), 64'(1));
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1 n++;
    end
    check("wr_start_lat", 64'(n), 64'(MD_LATENCY));
    check("wr_start_res_hi", 64'(hi), 64'(0));
    check("wr_start_res_lo", 64'(lo), 64'(15));

    @(negedge clk); op = MD_MULTU; rs_val = 32'hFFFF; rt_val = 32'hFFFF; start = 1'b1; wr_hi = 1'b1; wdata = 32'h77;
    @(posedge clk); #1 start = 1'b0; wr_hi = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    @(negedge clk) rst = 1'b0;
    run(MD_MULTU, 32'd6, 32'd7, -1);
    check("post_rst_lo", 64'(lo), 64'd42);
    check("post_rst_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 40; i++) run(2'($urandom_range(0, 3)), pick(), pick(), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
